// File: rtl/banana_pkg.sv
// banana_pkg: types and screen constants shared by the banana spawner and mover.
// Also holds the launch-Y clamp helper. The optional randomised launch Y is
// selected in banana_spawner.sv with BANANA_SPAWN_RANDOM_Y_EN.
package banana_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        REQUEST   = 2'd2,
        COOLDOWN  = 2'd3
    } spawner_state_t;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int SCREEN_H      = 480;
    localparam int OBJECT_H      = 16;
    localparam int SAFETY_MARGIN = 2;

    // Clamp a signed launch position into [lo, hi]. Negative values land on lo.
    function automatic logic [10:0] clamp_y(input logic signed [12:0] y,
                                            input logic [10:0]        lo,
                                            input logic [10:0]        hi);
        logic [10:0] r;
        if (y < $signed({2'b00, lo})) begin
            r = lo;
        end else if (y > $signed({2'b00, hi})) begin
            r = hi;
        end else begin
            r = y[10:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/banana_spawner_if.sv
// banana_spawner_if: request link between the banana spawner (master) and the mover (slave).
//
// Handshake: appear is a level request. Once it rises it stays high, with initial_y
// frozen, until the mover reports bananaActive=1 (accept) or the spawner abandons
// the request on timeout. Any cycle where appear=1 and bananaActive=1 is an accept.
// When bananaActive is already high as appear rises, the request is accepted at once
// and appear is high for exactly one cycle.
interface banana_spawner_if;
    logic        appear;
    logic [10:0] initial_y;
    logic        bananaActive;

    modport master (output appear, output initial_y, input bananaActive);
    modport slave  (input appear, input initial_y, output bananaActive);
endinterface

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR that advances once for each cycle in which step is high.
// A zero seed is replaced by 1 so the register can never lock up at zero.
module lfsr16
    import banana_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);
    logic [15:0] r_lfsr;
    logic [15:0] w_seed;
    logic [15:0] w_next;

    assign w_seed = (seed == 16'h0000) ? 16'h0001 : seed;
    assign w_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

    // Shift register: load the seed on reset, otherwise advance on each step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= w_seed;
        end else if (step) begin
            r_lfsr <= w_next;
        end
    end

    assign value = r_lfsr;
endmodule

// File: rtl/banana_spawner.sv
// banana_spawner: decides when a banana is thrown and from which Y.
// It counts frames to a jittered launch time, holds a request towards the mover,
// and enforces a cool-down after each accept or timeout.
// Optional feature: define BANANA_SPAWN_RANDOM_Y_EN to add LFSR jitter of
// -32..+31 pixels to the thrower's Y before clamping.
module banana_spawner
    import banana_pkg::*;
#(
    parameter int          SPAWN_PERIOD_FRAMES = 90,
    parameter logic [7:0]  JITTER_MASK         = 8'h1F,
    parameter int          MIN_GAP_FRAMES      = 30,
    parameter int          ACK_TIMEOUT_FRAMES  = 8,
    parameter int          Y_MIN               = 32,
    parameter int          Y_MAX               = 400,
    parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startOfFrame,
    input  logic             enable,
    input  logic [10:0]      throwerY,
    output logic [7:0]       spawnCount,
    output logic [7:0]       missCount,
    output spawner_state_t   o_dbg_state,
    banana_spawner_if.master mover
);
    // The highest Y from which the banana still fits on screen with its margin.
    localparam int          Y_LIMIT = SCREEN_H - 1 - SAFETY_MARGIN - OBJECT_H;
    localparam logic [10:0] Y_LO    = 11'(Y_MIN);
    localparam logic [10:0] Y_HI    = 11'((Y_MAX > Y_LIMIT) ? Y_LIMIT : Y_MAX);

    spawner_state_t r_state, w_state_nxt;
    logic [15:0]    r_frame_cnt, w_frame_cnt_nxt;
    logic [10:0]    r_initial_y, w_initial_y_nxt;
    logic [7:0]     r_spawn_cnt, w_spawn_cnt_nxt;
    logic [7:0]     r_miss_cnt, w_miss_cnt_nxt;

    logic [15:0]        w_lfsr;
    logic [15:0]        w_period;
    logic signed [12:0] w_raw_y;
    logic [10:0]        w_launch_y;
    logic               w_unused_lfsr_hi;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (startOfFrame),
        .seed  (LFSR_SEED),
        .value (w_lfsr)
    );

    // Only the low byte feeds period and position jitter.
    assign w_unused_lfsr_hi = ^w_lfsr[15:8];

    assign w_period = 16'(SPAWN_PERIOD_FRAMES) + {8'h00, w_lfsr[7:0] & JITTER_MASK};

`ifdef BANANA_SPAWN_RANDOM_Y_EN
    // 13 bits so that throwerY near 2047 plus jitter cannot wrap before the clamp.
    assign w_raw_y = $signed({2'b00, throwerY}) + $signed({7'b0, w_lfsr[5:0]}) - 13'sd32;
`else
    assign w_raw_y = $signed({2'b00, throwerY});
`endif

    assign w_launch_y = clamp_y(w_raw_y, Y_LO, Y_HI);

    // State and datapath registers; reset parks the spawner idle with cleared counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_frame_cnt <= '0;
            r_initial_y <= Y_LO;
            r_spawn_cnt <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_initial_y <= w_initial_y_nxt;
            r_spawn_cnt <= w_spawn_cnt_nxt;
            r_miss_cnt  <= w_miss_cnt_nxt;
        end
    end

    // Next-state logic: frame countdowns, request accept or timeout, and enable override.
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_initial_y_nxt = r_initial_y;
        w_spawn_cnt_nxt = r_spawn_cnt;
        w_miss_cnt_nxt  = r_miss_cnt;

        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt     = COUNTDOWN;
                    w_frame_cnt_nxt = w_period;
                end
                COUNTDOWN: begin
                    if (startOfFrame) begin
                        if (r_frame_cnt <= 16'd1) begin
                            w_state_nxt     = REQUEST;
                            w_initial_y_nxt = w_launch_y;
                            w_frame_cnt_nxt = 16'(ACK_TIMEOUT_FRAMES);
                        end else begin
                            w_frame_cnt_nxt = r_frame_cnt - 16'd1;
                        end
                    end
                end
                REQUEST: begin
                    // An accept takes priority over a timeout in the same cycle.
                    if (mover.bananaActive) begin
                        w_state_nxt     = COOLDOWN;
                        w_spawn_cnt_nxt = r_spawn_cnt + 8'd1;
                        w_frame_cnt_nxt = 16'(MIN_GAP_FRAMES);
                    end else if (startOfFrame) begin
                        if (r_frame_cnt <= 16'd1) begin
                            w_state_nxt     = COOLDOWN;
                            w_miss_cnt_nxt  = (r_miss_cnt == 8'hFF) ? r_miss_cnt : r_miss_cnt + 8'd1;
                            w_frame_cnt_nxt = 16'(MIN_GAP_FRAMES);
                        end else begin
                            w_frame_cnt_nxt = r_frame_cnt - 16'd1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (r_frame_cnt <= 16'd1) begin
                            w_state_nxt     = COUNTDOWN;
                            w_frame_cnt_nxt = w_period;
                        end else begin
                            w_frame_cnt_nxt = r_frame_cnt - 16'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign mover.appear    = (r_state == REQUEST);
    assign mover.initial_y = r_initial_y;
    assign spawnCount      = r_spawn_cnt;
    assign missCount       = r_miss_cnt;
    assign o_dbg_state     = r_state;
endmodule
